// File: rtl/lfb_pkg.sv
// Shared types and helpers for the reprogrammable Boolean function bank.
package lfb_pkg;

  typedef enum logic [1:0] {
    LFB_ST_IDLE  = 2'd0,
    LFB_ST_SWEEP = 2'd1,
    LFB_ST_DRAIN = 2'd2
  } lfb_state_e;

  // Truth-table depth for an n-input function.
  function automatic int lfb_w(input int n);
    return int'(32'd1 << n);
  endfunction

endpackage

// File: rtl/lfb_lut_col.sv
// One reprogrammable truth table: a W-bit register with write enable and a
// combinational bit select at the input-vector address.
module lfb_lut_col #(
  parameter int AW = 4,
  parameter int W = 16,
  parameter logic [W-1:0] DEF = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] addr,
  output logic          rd_bit
);

  logic [W-1:0] tbl_r;

  // Table storage; reads below see the pre-write contents in a write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_r <= DEF;
    end else if (we) begin
      tbl_r <= wdata;
    end
  end

  assign rd_bit = tbl_r[addr];

endmodule

// File: rtl/logic_func_bank.sv
// Registered bank of N_OUT run-time-programmable Boolean functions of N_IN
// inputs, with a valid/ready evaluation stream and a self-sweep mode.
module logic_func_bank
  import lfb_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_OUT = 10,
  localparam int W = lfb_w(N_IN),
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter logic [N_OUT*W-1:0] DEF_TBL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [W-1:0]     cfg_table,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             sweep_go,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_vec,
  output logic [N_IN-1:0]  out_idx,
  output logic             out_last
);

  // cnt is one bit wider than the address so W-1 is detected without wrapping.
  localparam logic [N_IN:0] LAST_CNT = (N_IN+1)'(W - 1);
  localparam logic [N_IN:0] CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

  lfb_state_e       state_r, state_nxt_s;
  logic [N_IN:0]    cnt_r, cnt_nxt_s;
  logic             busy_r, cfg_err_r;
  logic             out_valid_r, out_last_r;
  logic [N_OUT-1:0] out_vec_r, col_bits_s;
  logic [N_IN-1:0]  out_idx_r, addr_s;
  logic             adv_s, eval_acc_s, sweep_emit_s, load_s, last_s;
  logic             cfg_acc_s, cfg_bad_s;

  assign adv_s        = !out_valid_r || out_ready;
  assign in_ready     = (state_r == LFB_ST_IDLE) && !sweep_go && adv_s;
  assign eval_acc_s   = in_valid && in_ready;
  assign sweep_emit_s = (state_r == LFB_ST_SWEEP) && adv_s;
  assign load_s       = eval_acc_s || sweep_emit_s;
  assign last_s       = sweep_emit_s && (cnt_r == LAST_CNT);

  assign cfg_ready = !busy_r;
  assign cfg_acc_s = cfg_valid && !busy_r;
  assign cfg_bad_s = (int'($unsigned(cfg_idx)) >= N_OUT);

  // Table address: the sweep counter owns it while sweeping.
  always_comb begin
    addr_s = in_vec;
    if (state_r == LFB_ST_SWEEP) begin
      addr_s = cnt_r[N_IN-1:0];
    end else begin
      addr_s = in_vec;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_col
    logic we_s;
    assign we_s = cfg_acc_s && (cfg_idx == IDX_W'(k));
    lfb_lut_col #(
      .AW  (N_IN),
      .W   (W),
      .DEF (DEF_TBL[k*W +: W])
    ) u_col (
      .clk    (clk),
      .rst    (rst),
      .we     (we_s),
      .wdata  (cfg_table),
      .addr   (addr_s),
      .rd_bit (col_bits_s[k])
    );
  end

  // Sweep sequencer next-state and counter update.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      LFB_ST_IDLE: begin
        if (sweep_go) begin
          state_nxt_s = LFB_ST_SWEEP;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = LFB_ST_IDLE;
        end
      end
      LFB_ST_SWEEP: begin
        if (sweep_emit_s) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_nxt_s = LFB_ST_DRAIN;
          end else begin
            state_nxt_s = LFB_ST_SWEEP;
          end
        end else begin
          state_nxt_s = LFB_ST_SWEEP;
        end
      end
      LFB_ST_DRAIN: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = LFB_ST_IDLE;
        end else begin
          state_nxt_s = LFB_ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = LFB_ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counter and busy flag; busy falls the cycle after the last handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LFB_ST_IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != LFB_ST_IDLE);
    end
  end

  // Out-of-range config writes are dropped and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_acc_s && cfg_bad_s;
    end
  end

  // One-entry output register; payload holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_vec_r   <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_vec_r   <= col_bits_s;
      out_idx_r   <= addr_s;
      out_last_r  <= last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign cfg_err   = cfg_err_r;
  assign out_valid = out_valid_r;
  assign out_vec   = out_vec_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_logic_func_bank.sv
// Directed + randomized bench for logic_func_bank against a truth-table model.
module tb_logic_func_bank;

  localparam int N_IN  = 4;
  localparam int N_OUT = 10;
  localparam int W     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_idx;
  logic [W-1:0]     cfg_table;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             sweep_go;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_vec;
  logic [N_IN-1:0]  out_idx;
  logic             out_last;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] mtbl [N_OUT];

  logic_func_bank #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_table (cfg_table),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .sweep_go  (sweep_go),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [N_OUT-1:0] ref_vec(input int v);
    logic [N_OUT-1:0] r;
    for (int k = 0; k < N_OUT; k++) r[k] = mtbl[k][v];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [W-1:0] t);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_table = t;
    #1;
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'(idx >= 4'd10));
    if (int'(idx) < N_OUT) mtbl[idx] = t;
    tick();
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
  endtask

  task automatic do_eval(input logic [3:0] v);
    logic [N_OUT-1:0] e;
    e = ref_vec(int'(v));
    in_valid = 1'b1; in_vec = v; out_ready = 1'b1;
    #1;
    chk("eval_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("eval_valid", 32'(out_valid), 32'd1);
    chk("eval_vec", 32'(out_vec), 32'(e));
    chk("eval_idx", 32'(out_idx), 32'(v));
    chk("eval_last", 32'(out_last), 32'd0);
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_sweep(input int mode);
    int exp_i;
    int cyc;
    logic r;
    sweep_go = 1'b1; in_valid = 1'b1; in_vec = 4'($urandom); out_ready = 1'b1;
    #1;
    chk("sweep_go_blocks_eval", 32'(in_ready), 32'd0);
    tick();
    sweep_go = 1'b0;
    cfg_valid = 1'b1; cfg_idx = 4'd0; cfg_table = 16'($urandom);
    exp_i = 0;
    cyc = 0;
    while (exp_i < W && cyc < 200) begin
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_in_ready", 32'(in_ready), 32'd0);
      chk("sweep_cfg_ready", 32'(cfg_ready), 32'd0);
      if (out_valid) begin
        chk("sweep_idx", 32'(out_idx), 32'(exp_i));
        chk("sweep_vec", 32'(out_vec), 32'(ref_vec(exp_i)));
        chk("sweep_last", 32'(out_last), 32'(exp_i == W - 1));
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom);
      endcase
      out_ready = r;
      if (out_valid && r) exp_i++;
      if (exp_i == W) begin
        in_valid = 1'b0;
        cfg_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
    chk("sweep_complete", 32'(exp_i), 32'(W));
    chk("sweep_busy_drop", 32'(busy), 32'd0);
    chk("sweep_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [N_OUT-1:0] e;
    logic [3:0] v;
    int found;

    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = 4'd0; cfg_table = 16'h0000;
    in_valid = 1'b0; in_vec = 4'd0; sweep_go = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < N_OUT; k++) mtbl[k] = 16'h0000;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    tick();

    // f0 = wx' + xyz' + y'z
    cfg_write(4'd0, 16'h6F62);
    do_eval(4'd6);
    chk("t1_f0_at6", 32'(out_vec[0]), 32'd1);
    do_eval(4'd7);
    chk("t1_f0_at7", 32'(out_vec[0]), 32'd0);

    for (int k = 0; k < N_OUT; k++) cfg_write(4'(k), 16'($urandom));
    run_sweep(0);
    run_sweep(1);

    // Same-cycle write and eval: eval sees the old table.
    cfg_write(4'd0, 16'h0000);
    e = ref_vec(0);
    cfg_valid = 1'b1; cfg_idx = 4'd0; cfg_table = 16'hFFFF;
    in_valid = 1'b1; in_vec = 4'd0; out_ready = 1'b1;
    tick();
    cfg_valid = 1'b0; in_valid = 1'b0;
    mtbl[0] = 16'hFFFF;
    chk("t4_old_table_bit", 32'(out_vec[0]), 32'd0);
    chk("t4_old_table_vec", 32'(out_vec), 32'(e));
    do_eval(4'd0);
    chk("t4_new_table_bit", 32'(out_vec[0]), 32'd1);

    // Back-to-back evaluations at full throughput.
    for (int i = 0; i < 20; i++) begin
      v = 4'($urandom);
      in_valid = 1'b1; in_vec = v; out_ready = 1'b1;
      #1;
      chk("burst_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("burst_valid", 32'(out_valid), 32'd1);
      chk("burst_idx", 32'(out_idx), 32'(v));
      chk("burst_vec", 32'(out_vec), 32'(ref_vec(int'(v))));
    end
    in_valid = 1'b0;
    tick();

    cfg_write(4'd12, 16'($urandom));
    run_sweep(2);

    // Reset mid-sweep at vector 5.
    sweep_go = 1'b1; out_ready = 1'b1;
    tick();
    sweep_go = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (out_valid && out_idx == 4'd5) found = 1;
      else tick();
    end
    chk("t6_reached_vec5", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_valid_cleared", 32'(out_valid), 32'd0);
    chk("t6_busy_cleared", 32'(busy), 32'd0);
    chk("t6_last_cleared", 32'(out_last), 32'd0);
    chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < N_OUT; k++) mtbl[k] = 16'h0000;
    tick();
    run_sweep(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
